alert_responder: RTL and testbench

//  Consumer end of the anomaly detector's alert outputs. Samples the 8-bit alert bitmap every cycle,

---
 rtl/alert_responder.sv | 190 +++++++++++++++++++
 tb/tb_alert_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alert_responder.sv
// alert_responder: trading circuit-breaker FSM plus a timestamped alert-edge event FIFO.
// Define ALERT_RESP_AUTO_RESUME_EN to let a long-quiet HALT exit to COOLDOWN without an ack.
module alert_responder #(
  parameter int         FIFO_DEPTH   = 4,
  parameter int         PERSIST_CYC  = 4,
  parameter int         COOLDOWN_CYC = 16,
  parameter logic [7:0] CRIT_MASK    = 8'h80
`ifdef ALERT_RESP_AUTO_RESUME_EN
  ,
  parameter int         AUTO_RESUME_CYC = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alert_bitmap,
  input  logic        ack,
  input  logic        evt_ready,
  output logic        evt_valid,
  output logic [23:0] evt_data,
  output logic [7:0]  evt_overflow,
  output logic [7:0]  alert_sticky,
  output logic        trading_halt,
  output logic [1:0]  resp_state
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_WATCH  = 2'b01,
    ST_HALT   = 2'b10,
    ST_COOL   = 2'b11
  } state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 16;
  localparam logic [PTR_W:0]   DEPTH_C     = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] PERSIST_LIM = CNT_W'(PERSIST_CYC);
  localparam logic [CNT_W-1:0] COOL_LIM    = CNT_W'(COOLDOWN_CYC);
`ifdef ALERT_RESP_AUTO_RESUME_EN
  localparam logic [CNT_W-1:0] AUTO_LIM    = CNT_W'(AUTO_RESUME_CYC);
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             any, crit, ack_ok;
  logic [15:0]      ts;
  logic [7:0]       prev_bitmap;

  logic [7:0]       edge_p0;
  logic             vld_p0;
  logic [23:0]      evt_p0;

  logic [23:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [PTR_W:0]   fcnt, fcnt_nx;
  logic             pop, push, drop, full;
  logic [23:0]      head_nx;

  // Stage p0: classify the sampled bitmap and form the candidate event
  assign any     = |alert_bitmap;
  assign crit    = |(alert_bitmap & CRIT_MASK);
  assign cnt_inc = cnt + 1'b1;
  assign edge_p0 = alert_bitmap & ~prev_bitmap;
  assign vld_p0  = |edge_p0;
  assign evt_p0  = {ts, edge_p0};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ack_ok   = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (crit) begin
          state_nx = ST_HALT;
          cnt_nx   = '0;
        end else if (any) begin
          state_nx = ST_WATCH;
          cnt_nx   = CNT_W'(1);
        end
      end
      ST_WATCH: begin
        if (crit) begin
          state_nx = ST_HALT;
          cnt_nx   = '0;
        end else if (!any) begin
          state_nx = ST_NORMAL;
          cnt_nx   = '0;
        end else if (cnt_inc == PERSIST_LIM) begin
          state_nx = ST_HALT;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt_inc;
        end
      end
      ST_HALT: begin
        // An ack is honoured only once the bitmap has gone quiet
        if (ack && !any) begin
          state_nx = ST_COOL;
          cnt_nx   = '0;
          ack_ok   = 1'b1;
        end
`ifdef ALERT_RESP_AUTO_RESUME_EN
        else if (any) begin
          cnt_nx   = '0;
        end else if (cnt_inc == AUTO_LIM) begin
          state_nx = ST_COOL;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt_inc;
        end
`endif
      end
      ST_COOL: begin
        if (crit) begin
          state_nx = ST_HALT;
          cnt_nx   = '0;
        end else if (any) begin
          cnt_nx   = '0;
        end else if (cnt_inc == COOL_LIM) begin
          state_nx = ST_NORMAL;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt_inc;
        end
      end
      default: begin
        state_nx = ST_NORMAL;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    pop       = evt_valid & evt_ready;
    full      = (fcnt == DEPTH_C);
    push      = vld_p0 & (~full | pop);
    drop      = vld_p0 & full & ~pop;
    rd_ptr_nx = pop ? rd_ptr + 1'b1 : rd_ptr;
    fcnt_nx   = fcnt + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    // Head after this edge: the new entry if it lands at the next read slot
    head_nx   = (push && (wr_ptr == rd_ptr_nx)) ? evt_p0 : mem[rd_ptr_nx];
  end

  // Stage p1: registered responder state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_NORMAL;
      cnt          <= '0;
      trading_halt <= 1'b0;
      alert_sticky <= 8'h00;
      ts           <= 16'h0000;
      prev_bitmap  <= 8'h00;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      trading_halt <= (state_nx == ST_HALT);
      alert_sticky <= ack_ok ? alert_bitmap : (alert_sticky | alert_bitmap);
      ts           <= ts + 16'd1;
      prev_bitmap  <= alert_bitmap;
    end
  end

  assign resp_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= evt_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fcnt         <= '0;
      evt_valid    <= 1'b0;
      evt_data     <= 24'h000000;
      evt_overflow <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr_nx;
      fcnt      <= fcnt_nx;
      evt_valid <= (fcnt_nx != '0);
      evt_data  <= head_nx;
      if (drop) evt_overflow <= sat_inc8(evt_overflow);
    end
  end

endmodule

// File: tb/tb_alert_responder.sv
// tb_alert_responder: randomized + directed stimulus against a cycle-level behavioural model;
// event FIFO contents checked by a scoreboard queue drained by an independent monitor.
module tb_alert_responder;

  localparam int         DEPTH   = 4;
  localparam int         PERSIST = 4;
  localparam int         COOL    = 16;
  localparam logic [7:0] CRIT    = 8'h80;
`ifdef ALERT_RESP_AUTO_RESUME_EN
  localparam int         AUTO    = 64;
`endif
  localparam int M_NORMAL = 0, M_WATCH = 1, M_HALT = 2, M_COOL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  alert_bitmap = 8'h00;
  logic        ack = 1'b0;
  logic        evt_ready = 1'b0;
  logic        evt_valid;
  logic [23:0] evt_data;
  logic [7:0]  evt_overflow;
  logic [7:0]  alert_sticky;
  logic        trading_halt;
  logic [1:0]  resp_state;

  alert_responder #(
    .FIFO_DEPTH(DEPTH), .PERSIST_CYC(PERSIST), .COOLDOWN_CYC(COOL), .CRIT_MASK(CRIT)
`ifdef ALERT_RESP_AUTO_RESUME_EN
    , .AUTO_RESUME_CYC(AUTO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .alert_bitmap(alert_bitmap), .ack(ack), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_overflow(evt_overflow),
    .alert_sticky(alert_sticky), .trading_halt(trading_halt), .resp_state(resp_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_mode = M_NORMAL;
  int          m_run  = 0;
  logic [7:0]  m_sticky = 8'h00;
  logic [15:0] m_ts = 16'h0000;
  logic [7:0]  m_prev = 8'h00;
  int          m_fcnt = 0;
  int          m_ovf  = 0;
  logic [23:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic [7:0] b, input logic a, input logic rd);
    logic       is_any, is_crit, pop_now, accepted;
    logic [7:0] rise;
    if (r) begin
      m_mode = M_NORMAL; m_run = 0; m_sticky = 8'h00; m_ts = 16'h0000;
      m_prev = 8'h00; m_fcnt = 0; m_ovf = 0;
      exp_q.delete();
      return;
    end
    is_any  = (b != 8'h00);
    is_crit = ((b & CRIT) != 8'h00);
    rise    = b & ~m_prev;
    pop_now = (m_fcnt > 0) && rd;
    if (rise != 8'h00) begin
      if (m_fcnt < DEPTH || pop_now) begin
        exp_q.push_back({m_ts, rise});
        m_fcnt++;
      end else if (m_ovf < 255) begin
        m_ovf++;
      end
    end
    if (pop_now) m_fcnt--;
    accepted = (m_mode == M_HALT) && a && !is_any;
    m_sticky = accepted ? 8'h00 : (m_sticky | b);
    case (m_mode)
      M_NORMAL: begin
        if (is_crit) begin m_mode = M_HALT; m_run = 0; end
        else if (is_any) begin m_mode = M_WATCH; m_run = 1; end
      end
      M_WATCH: begin
        if (is_crit) begin m_mode = M_HALT; m_run = 0; end
        else if (!is_any) begin m_mode = M_NORMAL; m_run = 0; end
        else begin
          m_run++;
          if (m_run == PERSIST) begin m_mode = M_HALT; m_run = 0; end
        end
      end
      M_HALT: begin
        if (accepted) begin m_mode = M_COOL; m_run = 0; end
`ifdef ALERT_RESP_AUTO_RESUME_EN
        else if (is_any) m_run = 0;
        else begin
          m_run++;
          if (m_run == AUTO) begin m_mode = M_COOL; m_run = 0; end
        end
`endif
      end
      default: begin
        if (is_crit) begin m_mode = M_HALT; m_run = 0; end
        else if (is_any) m_run = 0;
        else begin
          m_run++;
          if (m_run == COOL) begin m_mode = M_NORMAL; m_run = 0; end
        end
      end
    endcase
    m_prev = b;
    m_ts   = m_ts + 16'd1;
  endtask

  task automatic step(input logic r, input logic [7:0] b, input logic a, input logic rd, input bit chk);
    rst = r; alert_bitmap = b; ack = a; evt_ready = rd;
    model(r, b, a, rd);
    @(posedge clk);
    #1;
    if (chk) begin
      check("resp_state",   32'(resp_state),   32'(m_mode));
      check("trading_halt", 32'(trading_halt), 32'(m_mode == M_HALT));
      check("alert_sticky", 32'(alert_sticky), 32'(m_sticky));
      check("evt_valid",    32'(evt_valid),    32'(m_fcnt > 0));
      check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
    end
  endtask

  // scoreboard monitor: a handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL evt_unexpected got=%06h expected=none", evt_data);
      end else begin
        e = exp_q.pop_front();
        check("evt_data", 32'(evt_data), 32'(e));
      end
    end
  end

  initial begin
    logic [7:0] cur_b;
    int         guard;
    // reset with bitmap high, then the first live cycle sees every bit rise
    step(1, 8'hFF, 0, 0, 1);
    step(1, 8'hFF, 0, 0, 1);
    step(0, 8'hFF, 0, 0, 1);
    step(0, 8'hFF, 0, 1, 1);
    step(0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 18; i++) step(0, 8'h00, 0, 1, 1);

    // non-critical persistence, then a drop before the limit
    step(1, 8'h00, 0, 1, 1);
    for (int i = 0; i < 9; i++) step(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 8'h02, 0, 1, 1);
    step(0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 17; i++) step(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 2; i++) step(0, 8'h02, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 1);

    // critical alert, ignored ack, accepted ack, cooldown
    for (int i = 0; i < 3; i++) step(0, 8'h80, 0, 1, 1);
    step(0, 8'h80, 1, 1, 1);
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 17; i++) step(0, 8'h00, 0, 1, 1);

    // FIFO fill with overflow, then push and pop on a full FIFO
    step(0, 8'h01, 0, 0, 1); step(0, 8'h00, 0, 0, 1);
    step(0, 8'h02, 0, 0, 1); step(0, 8'h00, 0, 0, 1);
    step(0, 8'h04, 0, 0, 1); step(0, 8'h00, 0, 0, 1);
    step(0, 8'h08, 0, 0, 1); step(0, 8'h00, 0, 0, 1);
    step(0, 8'h10, 0, 0, 1);
    step(0, 8'h30, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 1, 1);

    // randomized traffic with occasional mid-run reset
    cur_b = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 4) cur_b = 8'h00;
      else if (sel <= 7) cur_b = 8'($urandom_range(1, 127));
      else if (sel == 8) cur_b = 8'h80 | 8'($urandom_range(0, 127));
      step(($urandom_range(0, 299) == 0), cur_b, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1), 1);
    end

    // timestamp wrap: edges at FFFF and 0000
    for (int i = 0; i < 40; i++) step(0, 8'h00, (i == 0), 1, 1);
    guard = 0;
    while (m_ts != 16'hFFFF && guard < 70000) begin
      step(0, 8'h00, 0, 1, 0);
      guard++;
    end
    check("ts_reach_ffff", 32'(m_ts == 16'hFFFF && guard < 70000), 32'(1));
    step(0, 8'h01, 0, 1, 1);
    step(0, 8'h03, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1, 1);

    // long quiet HALT with no ack
    step(0, 8'h80, 0, 1, 1);
    for (int i = 0; i < 70; i++) step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 1, 1);

    check("fifo_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
